// File: rtl/adc_conv_sequencer.sv
// Conversion sequencer for the SAR-ADC core: holds/release core reset, counts OSR
// results into a small FWFT FIFO, and recovers a hung core with a watchdog.
module adc_conv_sequencer #(
  parameter int FIFO_DEPTH     = 4,
  parameter int RST_CYCLES     = 4,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_in,
  input  logic       stop_in,
  input  logic       continuous_in,
  input  logic [7:0] burst_len_in,
  input  logic [9:0] config_in,
  input  logic       clear_err_in,
  output logic       core_rst_n_out,
  output logic [9:0] core_config_out,
  input  logic       core_conv_done_in,
  input  logic [9:0] core_result_in,
  output logic       rd_valid_out,
  input  logic       rd_ready_in,
  output logic [9:0] rd_data_out,
  output logic       busy_out,
  output logic [4:0] fifo_level_out,
  output logic       overflow_err_out,
  output logic       timeout_err_out
);

  localparam int         AW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [3:0]  RST_LOAD = 4'(RST_CYCLES - 1);
  localparam logic [15:0] WD_LAST  = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [4:0]  DEPTH5   = 5'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_CORE_RST  = 2'd1,
    S_WAIT_DONE = 2'd2,
    S_RECOVER   = 2'd3
  } state_t;

  // Handshake: a FIFO entry moves to the consumer on every clk edge where
  // rd_valid_out and rd_ready_in are both 1; rd_data_out is the head whenever
  // rd_valid_out is 1 and never depends on rd_ready_in.

  // ------------------------------------------------------------------
  // Done strobe synchroniser and rising-edge detector
  // ------------------------------------------------------------------
  logic sync1_q, sync2_q, sync3_q, done_evt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      sync3_q    <= 1'b0;
      done_evt_q <= 1'b0;
    end else begin
      sync1_q    <= core_conv_done_in;
      sync2_q    <= sync1_q;
      sync3_q    <= sync2_q;
      done_evt_q <= sync2_q & ~sync3_q;
    end
  end

  // ------------------------------------------------------------------
  // Sequencer FSM
  // ------------------------------------------------------------------
  state_t      state_q;
  logic [3:0]  rst_cnt_q;
  logic [15:0] wd_q;
  logic [8:0]  remaining_q;
  logic        continuous_q;
  logic [9:0]  cfg_q;
  logic        core_rst_n_q;
  logic        timeout_err_q;
  logic        push;
  logic        trip;

  // Results are only meaningful while the core is running; stop does not mask them.
  assign push = done_evt_q && (state_q == S_WAIT_DONE);
  assign trip = (state_q == S_WAIT_DONE) && !stop_in && !done_evt_q && (wd_q == WD_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      rst_cnt_q     <= 4'd0;
      wd_q          <= 16'd0;
      remaining_q   <= 9'd0;
      continuous_q  <= 1'b0;
      cfg_q         <= 10'd0;
      core_rst_n_q  <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      timeout_err_q <= trip | (timeout_err_q & ~clear_err_in);
      case (state_q)
        S_IDLE: begin
          core_rst_n_q <= 1'b0;
          if (start_in) begin
            cfg_q        <= config_in;
            continuous_q <= continuous_in;
            remaining_q  <= (burst_len_in == 8'd0) ? 9'd256 : {1'b0, burst_len_in};
            rst_cnt_q    <= RST_LOAD;
            state_q      <= S_CORE_RST;
          end
        end
        S_CORE_RST, S_RECOVER: begin
          if (stop_in) begin
            state_q      <= S_IDLE;
            core_rst_n_q <= 1'b0;
          end else if (rst_cnt_q == 4'd0) begin
            state_q      <= S_WAIT_DONE;
            core_rst_n_q <= 1'b1;
            wd_q         <= 16'd0;
          end else begin
            rst_cnt_q <= rst_cnt_q - 4'd1;
          end
        end
        S_WAIT_DONE: begin
          if (stop_in) begin
            state_q      <= S_IDLE;
            core_rst_n_q <= 1'b0;
          end else if (done_evt_q) begin
            wd_q <= 16'd0;
            if (!continuous_q) begin
              remaining_q <= remaining_q - 9'd1;
              if (remaining_q == 9'd1) begin
                state_q      <= S_IDLE;
                core_rst_n_q <= 1'b0;
              end
            end
          end else if (wd_q == WD_LAST) begin
            // The in-flight result is lost; remaining is kept so it gets retried.
            state_q      <= S_RECOVER;
            core_rst_n_q <= 1'b0;
            rst_cnt_q    <= RST_LOAD;
          end else begin
            wd_q <= wd_q + 16'd1;
          end
        end
        default: begin
          state_q      <= S_IDLE;
          core_rst_n_q <= 1'b0;
        end
      endcase
    end
  end

  // ------------------------------------------------------------------
  // Result FIFO (first-word-fall-through)
  // ------------------------------------------------------------------
  logic [9:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [4:0]    level_q, level_d;
  logic          overflow_q;
  logic          empty, full, pop, push_ok, ovf_set;

  assign empty   = (level_q == 5'd0);
  assign full    = (level_q == DEPTH5);
  assign pop     = !empty && rd_ready_in;
  // A pop in the same cycle frees a slot, so a full FIFO can still accept.
  assign push_ok = push && (!full || pop);
  assign ovf_set = push && full && !pop;

  always_comb begin
    level_d = level_q;
    case ({push_ok, pop})
      2'b10:   level_d = level_q + 5'd1;
      2'b01:   level_d = level_q - 5'd1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= core_result_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= 5'd0;
      overflow_q <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      level_q    <= level_d;
      overflow_q <= ovf_set | (overflow_q & ~clear_err_in);
    end
  end

  // ------------------------------------------------------------------
  // Outputs
  // ------------------------------------------------------------------
  assign core_rst_n_out   = core_rst_n_q;
  assign core_config_out  = cfg_q;
  assign rd_valid_out     = !empty;
  assign rd_data_out      = empty ? 10'd0 : mem_q[rd_ptr_q];
  assign busy_out         = (state_q != S_IDLE);
  assign fifo_level_out   = level_q;
  assign overflow_err_out = overflow_q;
  assign timeout_err_out  = timeout_err_q;

endmodule

// File: tb/tb_adc_conv_sequencer.sv
// Directed bench for adc_conv_sequencer: results pushed on stimulus, popped and
// compared by a read-port monitor; control outputs checked inline.
module tb_adc_conv_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_in, stop_in, continuous_in, clear_err_in;
  logic [7:0] burst_len_in;
  logic [9:0] config_in;
  logic       core_rst_n_out;
  logic [9:0] core_config_out;
  logic       core_conv_done_in;
  logic [9:0] core_result_in;
  logic       rd_valid_out, rd_ready_in;
  logic [9:0] rd_data_out;
  logic       busy_out;
  logic [4:0] fifo_level_out;
  logic       overflow_err_out, timeout_err_out;

  logic [9:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;

  adc_conv_sequencer #(
    .FIFO_DEPTH(4), .RST_CYCLES(4), .TIMEOUT_CYCLES(20)
  ) dut (
    .clk(clk), .rst(rst),
    .start_in(start_in), .stop_in(stop_in), .continuous_in(continuous_in),
    .burst_len_in(burst_len_in), .config_in(config_in), .clear_err_in(clear_err_in),
    .core_rst_n_out(core_rst_n_out), .core_config_out(core_config_out),
    .core_conv_done_in(core_conv_done_in), .core_result_in(core_result_in),
    .rd_valid_out(rd_valid_out), .rd_ready_in(rd_ready_in), .rd_data_out(rd_data_out),
    .busy_out(busy_out), .fifo_level_out(fifo_level_out),
    .overflow_err_out(overflow_err_out), .timeout_err_out(timeout_err_out)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (!rst && rd_valid_out && rd_ready_in) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_read: got 0x%0h, expected no data", rd_data_out);
      end else begin
        logic [9:0] e;
        e = exp_q.pop_front();
        if (rd_data_out !== e) begin
          n_err++;
          $display("FAIL read_data: got 0x%0h expected 0x%0h", rd_data_out, e);
        end
      end
    end
  end

  // ---------------- driver / check tasks ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start_run(input logic [9:0] cfg, input logic cont, input logic [7:0] len);
    config_in     = cfg;
    continuous_in = cont;
    burst_len_in  = len;
    start_in      = 1'b1;
    tick(1);
    start_in      = 1'b0;
  endtask

  // Core strobe: result is held stable until well past the capture edge.
  task automatic pulse_done(input logic [9:0] val);
    core_result_in    = val;
    core_conv_done_in = 1'b1;
    tick(5);
    core_conv_done_in = 1'b0;
    tick(3);
  endtask

  // Counts negedge samples (including the current one) where core_rst_n_out == lvl.
  task automatic count_while(input logic lvl, output int n);
    n = 0;
    for (int i = 0; i < 200; i++) begin
      if (core_rst_n_out !== lvl) break;
      n++;
      @(negedge clk);
    end
  endtask

  task automatic wait_run();
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (core_rst_n_out) break;
    end
    check("run_started", core_rst_n_out, 1);
    tick(1);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 200; i++) begin
      if (exp_q.size() == 0 && !rd_valid_out) break;
      @(negedge clk);
    end
    check("drain_queue", exp_q.size(), 0);
    check("drain_valid", rd_valid_out, 0);
    tick(1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n_lo, n_hi;
    rst = 1'b1;
    start_in = 0; stop_in = 0; continuous_in = 0; clear_err_in = 0;
    burst_len_in = 0; config_in = 0; core_conv_done_in = 0; core_result_in = 0;
    rd_ready_in = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_core_rst_n", core_rst_n_out, 0);
    check("rst_config", core_config_out, 0);
    check("rst_valid", rd_valid_out, 0);
    check("rst_data", rd_data_out, 0);
    check("rst_busy", busy_out, 0);
    check("rst_level", fifo_level_out, 0);
    check("rst_ovf", overflow_err_out, 0);
    check("rst_tmo", timeout_err_out, 0);
    tick(1);

    // 1: plain burst of 3
    rd_ready_in = 1'b1;
    start_run(10'h0A5, 1'b0, 8'd3);
    @(negedge clk);
    check("t1_busy", busy_out, 1);
    count_while(1'b0, n_lo);
    check("t1_rst_low_cycles", n_lo, 4);
    check("t1_config", core_config_out, 10'h0A5);
    tick(1);
    exp_q.push_back(10'h101); pulse_done(10'h101);
    exp_q.push_back(10'h202); pulse_done(10'h202);
    check("t1_busy_mid", busy_out, 1);
    exp_q.push_back(10'h303); pulse_done(10'h303);
    check("t1_idle_busy", busy_out, 0);
    check("t1_idle_core_rst_n", core_rst_n_out, 0);
    wait_drain();

    // 2: overflow with stalled consumer
    rd_ready_in = 1'b0;
    start_run(10'h155, 1'b0, 8'd6);
    wait_run();
    exp_q.push_back(10'd1); pulse_done(10'd1);
    check("t2_level1", fifo_level_out, 1);
    check("t2_valid1", rd_valid_out, 1);
    exp_q.push_back(10'd2); pulse_done(10'd2);
    exp_q.push_back(10'd3); pulse_done(10'd3);
    exp_q.push_back(10'd4); pulse_done(10'd4);
    check("t2_level_full", fifo_level_out, 4);
    check("t2_no_ovf_yet", overflow_err_out, 0);
    pulse_done(10'd5);
    check("t2_ovf_set", overflow_err_out, 1);
    check("t2_level_sat", fifo_level_out, 4);
    check("t2_busy_5", busy_out, 1);
    pulse_done(10'd6);
    check("t2_idle_after_6", busy_out, 0);
    rd_ready_in = 1'b1;
    wait_drain();
    check("t2_level_empty", fifo_level_out, 0);
    clear_err_in = 1'b1; tick(1); clear_err_in = 1'b0;
    check("t2_ovf_cleared", overflow_err_out, 0);

    // 3: watchdog trip and retry
    start_run(10'h2F0, 1'b0, 8'd2);
    @(negedge clk);
    count_while(1'b0, n_lo);
    check("t3_first_rst_low", n_lo, 4);
    count_while(1'b1, n_hi);
    check("t3_wait_cycles_before_trip", n_hi, 20);
    check("t3_tmo_set", timeout_err_out, 1);
    count_while(1'b0, n_lo);
    check("t3_recover_low", n_lo, 4);
    check("t3_busy_recover", busy_out, 1);
    tick(1);
    exp_q.push_back(10'h155); pulse_done(10'h155);
    check("t3_busy_after_1", busy_out, 1);
    exp_q.push_back(10'h156); pulse_done(10'h156);
    check("t3_idle_after_2", busy_out, 0);
    check("t3_tmo_sticky", timeout_err_out, 1);
    clear_err_in = 1'b1; tick(1); clear_err_in = 1'b0;
    check("t3_tmo_cleared", timeout_err_out, 0);
    wait_drain();

    // 4: continuous with stop; start while busy ignored
    start_run(10'h3C3, 1'b1, 8'd2);
    wait_run();
    for (int i = 0; i < 10; i++) begin
      exp_q.push_back(10'(10'h010 + i));
      pulse_done(10'(10'h010 + i));
      if (i == 4) begin
        config_in = 10'h111; start_in = 1'b1; tick(1); start_in = 1'b0;
      end
    end
    check("t4_config_held", core_config_out, 10'h3C3);
    check("t4_busy_continuous", busy_out, 1);
    stop_in = 1'b1; tick(1); stop_in = 1'b0;
    @(negedge clk);
    check("t4_idle_after_stop", busy_out, 0);
    check("t4_core_rst_n_after_stop", core_rst_n_out, 0);
    tick(1);
    wait_drain();

    // 5: full FIFO with pop collision, then clear racing a new overflow
    rd_ready_in = 1'b0;
    start_run(10'h0F0, 1'b1, 8'd0);
    wait_run();
    for (int i = 1; i <= 4; i++) begin
      exp_q.push_back(10'(10'h2A0 + i));
      pulse_done(10'(10'h2A0 + i));
    end
    check("t5_full", fifo_level_out, 4);
    core_result_in = 10'h2A5; core_conv_done_in = 1'b1;
    exp_q.push_back(10'h2A5);
    tick(3);
    rd_ready_in = 1'b1;
    tick(1);
    rd_ready_in = 1'b0;
    check("t5_collide_level", fifo_level_out, 4);
    check("t5_collide_no_ovf", overflow_err_out, 0);
    tick(1); core_conv_done_in = 1'b0; tick(3);
    core_result_in = 10'h2A6; core_conv_done_in = 1'b1;
    tick(3);
    clear_err_in = 1'b1;
    tick(1);
    clear_err_in = 1'b0;
    check("t5_set_beats_clear", overflow_err_out, 1);
    tick(1); core_conv_done_in = 1'b0; tick(3);
    clear_err_in = 1'b1; tick(1); clear_err_in = 1'b0;
    check("t5_clear_alone", overflow_err_out, 0);
    stop_in = 1'b1; tick(1); stop_in = 1'b0;
    rd_ready_in = 1'b1;
    wait_drain();

    // 6: asynchronous reset mid-burst
    rd_ready_in = 1'b0;
    start_run(10'h3FF, 1'b0, 8'd5);
    wait_run();
    pulse_done(10'h0AA);
    pulse_done(10'h0BB);
    check("t6_level2", fifo_level_out, 2);
    check("t6_busy", busy_out, 1);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("t6_core_rst_n", core_rst_n_out, 0);
    check("t6_config", core_config_out, 0);
    check("t6_valid", rd_valid_out, 0);
    check("t6_data", rd_data_out, 0);
    check("t6_busy_rst", busy_out, 0);
    check("t6_level", fifo_level_out, 0);
    tick(1);
    rst = 1'b0;
    rd_ready_in = 1'b1;
    tick(5);
    check("t6_level_after", fifo_level_out, 0);
    check("t6_valid_after", rd_valid_out, 0);

    check("final_queue_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/adc_conv_sequencer.md
Name: adc_conv_sequencer

Overview:
- Conversion sequencer for the SAR-ADC core digital block (analog/digital interface with non-binary control, row/col decoders and OSR).
- Holds the core in reset while idle and latches its 10-bit configuration at start.
- Releases the core for a burst of N OSR results, or runs continuously.
- Collects results into a small first-word-fall-through FIFO with a valid/ready read port, and recovers a hung core with a watchdog.

Parameters:
- FIFO_DEPTH, 4, result FIFO entries; power of two, 2..16.
- RST_CYCLES, 4, cycles the core reset is held low on entry to CORE_RST and RECOVER; range 1..15.
- TIMEOUT_CYCLES, 1023, maximum clk cycles allowed between core results before a watchdog trip; range 1..65535.

Ports:
- clk  in  1  system clock; the only clock.
- rst  in  1  asynchronous, active-high reset.
- start_in  in  1  single-cycle start strobe; honoured only in IDLE.
- stop_in  in  1  abort request; honoured in any non-IDLE state.
- continuous_in  in  1  sampled at start; 1 = run until stop_in.
- burst_len_in  in  8  sampled at start; results per burst; 0 means 256.
- config_in  in  10  core configuration; sampled at start.
- clear_err_in  in  1  clears both sticky error flags.
- core_rst_n_out  out  1  core reset, active low.
- core_config_out  out  10  latched configuration, driven to the core config_1 input.
- core_conv_done_in  in  1  OSR conversion-finished strobe from the core; asynchronous to clk.
- core_result_in  in  10  core result; stable while core_conv_done_in is high.
- rd_valid_out  out  1  FIFO not empty.
- rd_ready_in  in  1  consumer accepts rd_data_out when rd_valid_out=1.
- rd_data_out  out  10  FIFO head.
- busy_out  out  1  state != IDLE.
- fifo_level_out  out  5  FIFO occupancy, 0..FIFO_DEPTH.
- overflow_err_out  out  1  sticky: a result was dropped because the FIFO was full.
- timeout_err_out  out  1  sticky: the watchdog tripped.

Behaviour:
- Reset values: core_rst_n_out=0, core_config_out=0, rd_valid_out=0, rd_data_out=0, busy_out=0, fifo_level_out=0, both error flags 0, state=IDLE. Synchroniser, counters and FIFO pointers all clear.
- Done detection:
  - core_conv_done_in goes through a 2-flop synchroniser, then a rising-edge register.
  - done_evt is a 1-cycle pulse on the third clk edge after the input rises.
  - core_result_in is captured into the FIFO on the done_evt cycle.
- States:
  - IDLE: core_rst_n_out=0. On start_in, latch config_in, continuous_in and burst_len_in into remaining (0 loads 256), then go to CORE_RST.
  - CORE_RST: core_rst_n_out=0 for RST_CYCLES cycles, then go to WAIT_DONE.
  - WAIT_DONE: core_rst_n_out=1; the watchdog counts every cycle.
    - On done_evt: push the result, clear the watchdog, and decrement remaining unless continuous.
    - If remaining becomes 0: go to IDLE.
    - If the watchdog reaches TIMEOUT_CYCLES: set timeout_err_out, go to RECOVER; remaining is unchanged.
  - RECOVER: core_rst_n_out=0 for RST_CYCLES cycles, then return to WAIT_DONE; the lost result is retried.
- stop_in in any non-IDLE state: go to IDLE on the next edge. A done_evt in that same cycle is still pushed.
- Priority when events coincide: stop_in > done_evt > watchdog trip.
- done_evt outside WAIT_DONE is ignored, including done_evt in CORE_RST or RECOVER.
- FIFO:
  - First-word-fall-through: rd_data_out equals the head whenever rd_valid_out=1. A push into an empty FIFO shows rd_valid_out=1 on the next cycle.
  - Pop when rd_valid_out and rd_ready_in are both 1.
  - Push when full: the result is dropped and overflow_err_out is set. The burst count still decrements.
  - Simultaneous push and pop when full: both proceed, no overflow, level unchanged.
  - FIFO contents are kept across stop and IDLE; only rst clears them.
- Sticky errors: set has priority over clear_err_in in the same cycle.
- The latched configuration holds until the next accepted start; core_config_out never changes while busy.
- Asserting rst mid-operation returns everything to its reset values immediately.

Test Plan:
1. Burst run: config_in=0x0A5, burst_len_in=3, core pulses done with results 0x101, 0x202, 0x303, consumer always ready → core_config_out=0x0A5; core_rst_n_out low for exactly 4 cycles, then high; three reads in order; IDLE with core_rst_n_out=0 after the third done_evt; busy_out=0.
2. Overflow: burst_len_in=6, rd_ready_in=0 → fifo_level_out saturates at 4; overflow_err_out=1 on the 5th result; returns to IDLE after the 6th; reads yield results 1..4 only.
3. Watchdog: TIMEOUT_CYCLES=20, no done pulse → timeout_err_out=1 at cycle 20 of WAIT_DONE; core_rst_n_out low for 4 cycles; back in WAIT_DONE; a subsequent done still counts toward burst_len.
4. Continuous with stop: continuous_in=1, 10 done pulses, then stop_in → 10 results delivered; IDLE the cycle after stop; start_in while busy is ignored (core_config_out unchanged).
5. Full plus pop collision and clear: FIFO full, done_evt coincides with a pop → level stays 4, no overflow. clear_err_in together with a new overflow → flag remains 1.
6. Async reset mid-burst: rst pulsed in WAIT_DONE with 2 entries queued → all outputs take their reset values; the FIFO is empty afterwards.
